// File: rtl/exp5_pkg.sv
// Shared definitions for the exp5 memory-sequence game control unit:
// state codes (also used by the debug display decoder), the FSM state type
// and the state-to-output decode helper.
package exp5_pkg;

    // 4-bit state codes as shown on the debug display
    localparam logic [3:0] ST_INICIAL     = 4'b0000;
    localparam logic [3:0] ST_PREPARACAO  = 4'b0001;
    localparam logic [3:0] ST_ESPERA      = 4'b0010;
    localparam logic [3:0] ST_REGISTRA    = 4'b0100;
    localparam logic [3:0] ST_COMPARACAO  = 4'b0101;
    localparam logic [3:0] ST_PROXIMO     = 4'b0110;
    localparam logic [3:0] ST_FIM_ACERTOU = 4'b1010;
    localparam logic [3:0] ST_FIM_TIMEOUT = 4'b1101;
    localparam logic [3:0] ST_FIM_ERROU   = 4'b1110;

    typedef enum logic [3:0] {
        S_INICIAL     = ST_INICIAL,
        S_PREPARACAO  = ST_PREPARACAO,
        S_ESPERA      = ST_ESPERA,
        S_REGISTRA    = ST_REGISTRA,
        S_COMPARACAO  = ST_COMPARACAO,
        S_PROXIMO     = ST_PROXIMO,
        S_FIM_ACERTOU = ST_FIM_ACERTOU,
        S_FIM_TIMEOUT = ST_FIM_TIMEOUT,
        S_FIM_ERROU   = ST_FIM_ERROU
    } state_t;

    // Control/status outputs of the unit, one bit each
    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
    } uc_out_t;

    // Moore decode: outputs depend on the state code only
    function automatic uc_out_t decode_outputs(input state_t st);
        uc_out_t o;
        o = '{zera_c: 1'b0, conta_c: 1'b0, zera_r: 1'b0, registra_r: 1'b0,
              pronto: 1'b0, acertou: 1'b0, errou: 1'b0};
        case (st)
            S_PREPARACAO: begin
                o.zera_c = 1'b1;
                o.zera_r = 1'b1;
            end
            S_REGISTRA:   o.registra_r = 1'b1;
            S_PROXIMO:    o.conta_c    = 1'b1;
            S_FIM_ACERTOU: begin
                o.pronto  = 1'b1;
                o.acertou = 1'b1;
            end
            S_FIM_ERROU: begin
                o.pronto = 1'b1;
                o.errou  = 1'b1;
            end
            S_FIM_TIMEOUT: begin
                o.pronto = 1'b1;
                o.errou  = 1'b1;
            end
            default: o = o;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/exp5_unidade_controle_timeout_counter.sv
// Wait-state cycle counter for the exp5 control unit. Cleared while the
// FSM is outside espera, counts each cycle spent in espera and flags the
// last allowed cycle. Only instantiated when EXP5_UC_TIMEOUT_EN is defined.
module exp5_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd5000
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CW-1:0] ONE  = CW'(32'd1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          terminal_r;

    // Next count: clear wins, otherwise count up and hold at the last value
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = {CW{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_next_s = count_r + ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register and registered terminal flag matching the new count
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= {CW{1'b0}};
            terminal_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            terminal_r <= (count_next_s == LAST);
        end
    end

    assign terminal = terminal_r;

endmodule

// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the exp5 memory-sequence game. Sequences one round
// against exp5_fluxo_dados: wait for a move, register it, compare with the
// ROM entry, advance the address, finish on full hit or first miss.
// Optional wait-state timeout enabled by defining EXP5_UC_TIMEOUT_EN.
// Outputs are registered from the decode of the next state, so they change
// on the same edge as the state and behave exactly like a state decode.
module exp5_unidade_controle
    import exp5_pkg::*;
`ifdef EXP5_UC_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd5000
)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] db_estado
);

    state_t     state_r;
    state_t     state_next_s;
    uc_out_t    outs_r;
    logic [3:0] db_estado_r;
    logic       timeout_s;

`ifdef EXP5_UC_TIMEOUT_EN
    logic tmo_clear_s;
    logic tmo_enable_s;

    assign tmo_clear_s  = (state_r != S_ESPERA);
    assign tmo_enable_s = (state_r == S_ESPERA);

    exp5_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .rst_n    (reset),
        .clear    (tmo_clear_s),
        .enable   (tmo_enable_s),
        .terminal (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic; unused codes fall back to inicial
    always_comb begin
        state_next_s = S_INICIAL;
        case (state_r)
            S_INICIAL: begin
                if (iniciar) state_next_s = S_PREPARACAO;
                else         state_next_s = S_INICIAL;
            end
            S_PREPARACAO: state_next_s = S_ESPERA;
            S_ESPERA: begin
                // a move on the final allowed cycle still beats the timeout
                if (jogada_feita)   state_next_s = S_REGISTRA;
                else if (timeout_s) state_next_s = S_FIM_TIMEOUT;
                else                state_next_s = S_ESPERA;
            end
            S_REGISTRA: state_next_s = S_COMPARACAO;
            S_COMPARACAO: begin
                // a miss at the last address is still an error
                if (!igual)    state_next_s = S_FIM_ERROU;
                else if (fimC) state_next_s = S_FIM_ACERTOU;
                else           state_next_s = S_PROXIMO;
            end
            S_PROXIMO: state_next_s = S_ESPERA;
            S_FIM_ACERTOU: begin
                if (iniciar) state_next_s = S_PREPARACAO;
                else         state_next_s = S_FIM_ACERTOU;
            end
            S_FIM_ERROU: begin
                if (iniciar) state_next_s = S_PREPARACAO;
                else         state_next_s = S_FIM_ERROU;
            end
`ifdef EXP5_UC_TIMEOUT_EN
            S_FIM_TIMEOUT: begin
                if (iniciar) state_next_s = S_PREPARACAO;
                else         state_next_s = S_FIM_TIMEOUT;
            end
`endif
            default: state_next_s = S_INICIAL;
        endcase
    end

    // State register plus registered output decode and debug code
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= S_INICIAL;
            outs_r      <= '{zera_c: 1'b0, conta_c: 1'b0, zera_r: 1'b0,
                             registra_r: 1'b0, pronto: 1'b0, acertou: 1'b0,
                             errou: 1'b0};
            db_estado_r <= ST_INICIAL;
        end else begin
            state_r     <= state_next_s;
            outs_r      <= decode_outputs(state_next_s);
            db_estado_r <= state_next_s;
        end
    end

    assign zeraC     = outs_r.zera_c;
    assign contaC    = outs_r.conta_c;
    assign zeraR     = outs_r.zera_r;
    assign registraR = outs_r.registra_r;
    assign pronto    = outs_r.pronto;
    assign acertou   = outs_r.acertou;
    assign errou     = outs_r.errou;
    assign db_estado = db_estado_r;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed self-checking bench for exp5_unidade_controle. Expected state
// codes are queued as each cycle's stimulus is driven and popped/compared
// after the clock edge. Timeout steps run only with EXP5_UC_TIMEOUT_EN.
module tb_exp5_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic [3:0] db_estado;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         reg_cnt  = 0;
    int         cnt_cnt  = 0;
    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

`ifdef EXP5_UC_TIMEOUT_EN
    exp5_unidade_controle #(.TIMEOUT_CYCLES(8)) dut (
`else
    exp5_unidade_controle dut (
`endif
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .fimC         (fimC),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .db_estado    (db_estado)
    );

    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou} per state code
    function automatic logic [6:0] exp_outs(input logic [3:0] st);
        case (st)
            4'b0001: return 7'b1010000;
            4'b0100: return 7'b0001000;
            4'b0110: return 7'b0100000;
            4'b1010: return 7'b0000110;
            4'b1110: return 7'b0000101;
            4'b1101: return 7'b0000101;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check_state(input string tag, input logic [3:0] exp);
        logic [6:0] obs;
        obs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou};
        n_checks++;
        assert (db_estado === exp) else begin
            n_fail++;
            $error("FAIL %s db_estado observed=%b expected=%b", tag, db_estado, exp);
        end
        n_checks++;
        assert (obs === exp_outs(exp)) else begin
            n_fail++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_outs(exp));
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue expected state, clock, pop and compare
    task automatic cyc(input logic ini, input logic jf, input logic ig,
                       input logic fc, input logic [3:0] exp, input string tag);
        logic [3:0] e;
        iniciar      = ini;
        jogada_feita = jf;
        igual        = ig;
        fimC         = fc;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        reg_cnt += int'(registraR);
        cnt_cnt += int'(contaC);
        e = exp_q.pop_front();
        check_state(tag, e);
    endtask

    // One move from espera: registra, comparacao, verdict (and espera after proximo)
    task automatic move(input logic ig, input logic fc, input logic [3:0] verdict);
        cyc(1'b0, 1'b1, ig, fc, 4'b0100, "registra");
        cyc(1'b0, 1'b0, ig, fc, 4'b0101, "comparacao");
        cyc(1'b0, 1'b0, ig, fc, verdict, "verdict");
        if (verdict == 4'b0110) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "back_espera");
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;
        #1 reset = 1'b0;
        #1 check_state("reset", 4'b0000);
        @(posedge clock); #1;
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "preparacao");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "espera");

        // asynchronous reset mid-espera
        #2 reset = 1'b0;
        #1 check_state("reset_async", 4'b0000);
        @(posedge clock); #1;
        check_state("reset_hold", 4'b0000);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "inicial_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "prep2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "espera2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, "ini_ignored_espera");

        // full hit: 16 moves, fimC only on the last; contaC only via proximo
        reg_cnt = 0; cnt_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) move(1'b1, 1'b1, 4'b1010);
            else         move(1'b1, 1'b0, 4'b0110);
        end
        check_val("hit_registraR_count", reg_cnt, 16);
        check_val("hit_contaC_count", cnt_cnt, 15);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, "hold_acertou");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, "jf_ignored_acertou");

        // miss on the 3rd move, then restart
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "restart_acertou");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "espera3");
        move(1'b1, 1'b0, 4'b0110);
        move(1'b1, 1'b0, 4'b0110);
        move(1'b0, 1'b0, 4'b1110);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, "hold_errou");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "restart_errou");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "espera4");

        // miss at the terminal address is an error
        move(1'b0, 1'b1, 4'b1110);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "restart_prio");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, "ini_ignored_prep");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "espera5");

        // pulses in registra/comparacao/proximo are dropped
        reg_cnt = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, "drop_registra");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0101, "drop_comparacao");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, "drop_proximo");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, "drop_to_espera");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "no_queue");
        check_val("drop_registraR_count", reg_cnt, 1);

        // iniciar held high restarts on entry to fim_errou
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, "held_registra");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, "held_comparacao");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, "held_errou");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "held_restart");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "espera6");

`ifdef EXP5_UC_TIMEOUT_EN
        // 8 cycles in espera with no move -> timeout
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "tmo_wait");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b1101, "tmo_expire");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b1101, "tmo_hold");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "tmo_restart");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "tmo_espera");
        // move on the 8th cycle wins over the timeout
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "tmo_wait2");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, "tmo_move_wins");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, "tmo_comparacao");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
